// File: rtl/alu_seq_ctrl_pkg.sv
// Shared op codes, FSM state encoding and default datapath width for the ALU
// sequencing controller and its iterative multiply/divide unit.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

package alu_seq_ctrl_pkg;

  localparam int DEF_D_WIDTH = `D_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIVU = 3'd3,
    OP_SLL  = 3'd4,
    OP_SRL  = 3'd5,
    OP_REMU = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per
// cycle for D_WIDTH cycles; done_o flags the final step, result_o is its output.
module mdu_iter #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               div_i,
  input  logic               rem_i,
  input  logic [D_WIDTH-1:0] a_i,
  input  logic [D_WIDTH-1:0] b_i,
  output logic               done_o,
  output logic [D_WIDTH-1:0] result_o
);

  localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(D_WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, rem_q, rem_d;
  // acc: product accumulator or partial remainder
  // sh : multiplier (shifts right) or dividend->quotient (shifts left)
  // opb: multiplicand (shifts left) or divisor
  logic [D_WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
  logic [D_WIDTH:0]   rem_sh;
  logic               ge;

  assign rem_sh = {acc_q, sh_q[D_WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, opb_q};
  assign done_o = busy_q & (cnt_q == CNT_LAST);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    rem_d  = rem_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    opb_d  = opb_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = div_i;
      rem_d  = rem_i;
      acc_d  = '0;
      sh_d   = div_i ? a_i : b_i;
      opb_d  = div_i ? b_i : a_i;
    end else if (busy_q) begin
      if (div_q) begin
        acc_d = ge ? D_WIDTH'(rem_sh - {1'b0, opb_q}) : rem_sh[D_WIDTH-1:0];
        sh_d  = {sh_q[D_WIDTH-2:0], ge};
      end else begin
        acc_d = acc_q + (sh_q[0] ? opb_q : '0);
        sh_d  = sh_q >> 1;
        opb_d = opb_q << 1;
      end
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign result_o = (div_q && !rem_q) ? sh_d : acc_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
      acc_q  <= '0;
      sh_q   <= '0;
      opb_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      rem_q  <= rem_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opb_q  <= opb_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer: single-cycle ops go through the shared external
// ALU, mul/divu/remu through mdu_iter, error cases answer directly.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [D_WIDTH-1:0] req_a,
  input  logic [D_WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err,
  output logic               alu_enable,
  output logic [2:0]         alu_op_code,
  output logic [D_WIDTH-1:0] alu_operand1,
  output logic [D_WIDTH-1:0] alu_operand2,
  input  logic [D_WIDTH-1:0] alu_result
);

  state_e             state_q, state_d;
  op_e                op_q, op_d, req_op_e;
  logic [D_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               err_q, err_d;
  logic               accept, mdu_start, mdu_done;
  logic [D_WIDTH-1:0] mdu_res;

  assign req_op_e  = op_e'(req_op);
  assign req_ready = (state_q == S_IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    res_d     = res_q;
    err_d     = err_q;
    mdu_start = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        op_d  = req_op_e;
        a_d   = req_a;
        b_d   = req_b;
        tag_d = req_tag;
        err_d = 1'b0;
        case (req_op_e)
          OP_MUL: begin
            state_d   = S_MUL;
            mdu_start = 1'b1;
          end
          OP_DIVU, OP_REMU: begin
            if (req_b == '0) begin
              state_d = S_DONE;
              err_d   = 1'b1;
              res_d   = (req_op_e == OP_DIVU) ? '1 : req_a;
            end else begin
              state_d   = S_DIV;
              mdu_start = 1'b1;
            end
          end
          OP_ILL: begin
            state_d = S_DONE;
            err_d   = 1'b1;
            res_d   = '0;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        res_d   = alu_result;
        state_d = S_DONE;
      end
      S_MUL, S_DIV: if (mdu_done) begin
        res_d   = mdu_res;
        state_d = S_DONE;
      end
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU is only driven while executing so it stays quiet otherwise
  assign alu_enable   = (state_q == S_EXEC);
  assign alu_op_code  = alu_enable ? op_q : 3'd0;
  assign alu_operand1 = alu_enable ? a_q : '0;
  assign alu_operand2 = alu_enable ? b_q : '0;

  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_result = res_q;
  assign rsp_tag    = tag_q;
  assign rsp_err    = err_q;

  mdu_iter #(.D_WIDTH(D_WIDTH)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mdu_start),
    .div_i    (req_op_e != OP_MUL),
    .rem_i    (req_op_e == OP_REMU),
    .a_i      (req_a),
    .b_i      (req_b),
    .done_o   (mdu_done),
    .result_o (mdu_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter D_WIDTH, default `D_WIDTH (32), datapath width.
REQ-002 Parameter TAG_W, default 5, destination-register tag width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_op  input  3  op code: 0 add, 1 sub, 2 mul, 3 divu, 4 sll, 5 srl, 6 remu, 7 illegal.
REQ-008 req_a, req_b  input  D_WIDTH each  operands.
REQ-009 req_tag  input  TAG_W  tag returned with result.
REQ-010 rsp_valid  output  1  result present.
REQ-011 rsp_ready  input  1  consumer takes result.
REQ-012 rsp_result  output  D_WIDTH  result.
REQ-013 rsp_tag  output  TAG_W  tag of request.
REQ-014 rsp_err  output  1  divide-by-zero or illegal op.
REQ-015 alu_enable, alu_op_code[2:0], alu_operand1/alu_operand2[D_WIDTH]  outputs  drive the shared single-cycle ALU.
REQ-016 alu_result  input  D_WIDTH  combinational ALU result.

Function
REQ-017 States SHALL be IDLE, EXEC, MUL, DIV, DONE.
REQ-018 req_ready SHALL be 1 exactly in IDLE; accept = req_valid & req_ready on a rising edge.
REQ-019 On accept, op, operands and tag SHALL be latched; later input changes ignored until next accept.
REQ-020 Ops 0,1,4,5: IDLE->EXEC; in EXEC alu_enable=1, alu_op_code=op, operands = latched a,b; next edge captures alu_result, ->DONE; rsp_valid asserted 2 cycles after accept edge.
REQ-021 alu_enable SHALL be 0 in every state except EXEC; ALU is never used for ops 2,3,6.
REQ-022 Op 2: IDLE->MUL; unsigned shift-add, one multiplier bit per cycle, D_WIDTH cycles, result = low D_WIDTH bits of a*b; rsp_valid D_WIDTH+1 cycles after accept.
REQ-023 Ops 3,6: IDLE->DIV; unsigned restoring division, one quotient bit per cycle, D_WIDTH cycles; op 3 returns quotient, op 6 remainder; same latency as REQ-022.
REQ-024 Ops 3,6 with b==0: IDLE->DONE directly (rsp_valid 1 cycle after accept), rsp_err=1; result all-ones for op 3, a for op 6.
REQ-025 Op 7: IDLE->DONE, rsp_result=0, rsp_err=1.
REQ-026 Iteration counter SHALL count 0..D_WIDTH-1 and leave MUL/DIV on terminal count; no wrap.
REQ-027 rsp_valid SHALL be 1 exactly in DONE; rsp_result, rsp_tag, rsp_err stable while in DONE.
REQ-028 DONE with rsp_ready=1 ->IDLE next edge; with rsp_ready=0 hold indefinitely (backpressure).
REQ-029 No new accept in DONE same cycle as response handshake; back-to-back throughput ≤ one op per 3 cycles (single-cycle ops).
REQ-030 rsp_err SHALL be 0 for all non-error results.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0, alu_enable=0, counter=0, from any state including mid-MUL/DIV; in-flight op discarded, no response.
REQ-032 req_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.

Structure
REQ-033 Op-code and state-encoding constants SHALL live in shared define.h alongside D_WIDTH.
REQ-034 Iterative multiply/divide datapath (accumulator, shift registers, counter) SHALL be one sub-module mdu_iter with start/done handshake; FSM and ALU sequencing remain in alu_seq_ctrl.

Verification
REQ-035 add a=5,b=7,tag=3, rsp_ready=1 -> alu_enable pulse 1 cycle with op 0, rsp_valid 2 cycles after accept, result 12, tag 3, err 0.
REQ-036 mul a=0xFFFF_FFFF,b=2 -> result 0xFFFF_FFFE after 33 cycles; divu a=100,b=7 -> 14; remu a=100,b=7 -> 2.
REQ-037 divu a=9,b=0 -> rsp_valid 1 cycle after accept, result 0xFFFF_FFFF, err 1; op 7 -> result 0, err 1.
REQ-038 rsp_ready held 0 for 10 cycles after sub a=3,b=5 -> rsp_valid, result 0xFFFF_FFFE stable, req_ready 0 throughout; release -> IDLE next edge.
REQ-039 rst_n=0 at cycle 10 of a mul -> next cycle IDLE, rsp_valid 0, no response emitted; following add 1+1 returns 2.
REQ-040 req_a/req_b toggled during DIV of 1000/10 -> result 100 (latched operands).
